// File: rtl/skolem_harness_pkg.sv
// Shared types and constants for the Skolem-function truth-table harness.
// Holds the sweep FSM encoding and the signature defaults.
package skolem_harness_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SAMPLE = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [15:0] DEF_POLY = 16'h1021;

    // Wide enough for any practical SIG_W; users take the low SIG_W bits.
    localparam logic [63:0] SIG_INIT = '1;

endpackage

// File: rtl/skolem_sig_crc.sv
// Serial CRC signature register, one bit per enabled cycle.
// Clear loads the all-ones seed; clear wins over enable.
module skolem_sig_crc
    import skolem_harness_pkg::*;
#(
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q, sig_d;
    logic             fb;

    always_comb begin
        fb    = sig_q[SIG_W-1] ^ bit_i;
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = SIG_INIT[SIG_W-1:0];
        end else if (en_i) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= SIG_INIT[SIG_W-1:0];
        else     sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/skolem_tt_sweeper.sv
// Exhaustive truth-table sweeper for a combinational Skolem function:
// drives every input vector, packs samples into words, signs the stream.
module skolem_tt_sweeper
    import skolem_harness_pkg::*;
#(
    parameter int               N_IN   = 8,
    parameter int               SETTLE = 1,
    parameter int               WORD_W = 8,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   vec_o,
    input  logic              f_i,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic [WORD_W-1:0] tt_data,
    output logic              tt_last,
    output logic [N_IN:0]     ones_cnt,
    output logic [SIG_W-1:0]  signature,
    input  logic [SIG_W-1:0]  golden_sig,
    output logic              sig_match
);

    localparam int              LW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int              CW        = $clog2(SETTLE + 2);
    localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;
    localparam logic [N_IN-1:0] POS_MASK  = N_IN'(WORD_W - 1);
    localparam state_e          ST_VEC    = (SETTLE == 0) ? S_SAMPLE : S_DRIVE;

    if (N_IN < $clog2(WORD_W) || ((1 << N_IN) % WORD_W) != 0) begin : g_bad_cfg
        $error("skolem_tt_sweeper: 2**N_IN must be a multiple of WORD_W");
    end

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CW-1:0]     settle_q, settle_d;
    logic [LW-1:0]     pos;
    logic              word_end;
    logic              crc_clr, crc_en;

    assign pos      = LW'(vec_q & POS_MASK);
    assign word_end = (pos == LW'(WORD_W - 1));

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        ones_d   = ones_q;
        word_d   = word_q;
        settle_d = settle_q;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d    = '0;
                    ones_d   = '0;
                    word_d   = '0;
                    settle_d = SETTLE_LD;
                    crc_clr  = 1'b1;
                    state_d  = ST_VEC;
                end
            end
            S_DRIVE: begin
                settle_d = settle_q - CW'(1);
                if (settle_q <= CW'(1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                word_d[pos] = f_i;
                ones_d      = ones_q + (N_IN+1)'(f_i);
                crc_en      = 1'b1;
                if (word_end) begin
                    state_d = S_EMIT;
                end else begin
                    vec_d    = vec_q + N_IN'(1);
                    settle_d = SETTLE_LD;
                    state_d  = ST_VEC;
                end
            end
            S_EMIT: begin
                // vec_q is held until the consumer takes the word
                if (tt_ready) begin
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d    = vec_q + N_IN'(1);
                        settle_d = SETTLE_LD;
                        state_d  = ST_VEC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            ones_q   <= '0;
            word_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            ones_q   <= ones_d;
            word_q   <= word_d;
            settle_q <= settle_d;
        end
    end

    skolem_sig_crc #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (f_i),
        .sig_o (signature)
    );

    assign busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE) || (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign vec_o     = vec_q;
    assign tt_valid  = (state_q == S_EMIT);
    assign tt_data   = word_q;
    assign tt_last   = tt_valid && (vec_q == VEC_LAST);
    assign ones_cnt  = ones_q;
    assign sig_match = done && (signature == golden_sig);

endmodule

// File: tb/tb_skolem_tt_sweeper.sv
// Scoreboard bench for skolem_tt_sweeper: SETTLE=1 and SETTLE=0 instances
// checked against a truth-table reference model.
module tb_skolem_tt_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, busy, done, f_i, tt_valid, tt_ready, tt_last, sig_match;
    logic [7:0]  vec_o, tt_data;
    logic [8:0]  ones_cnt;
    logic [15:0] signature, golden_sig;

    logic        start0, busy0, done0, f0, tt_valid0, tt_ready0, tt_last0, sig_match0;
    logic [7:0]  vec0, tt_data0;
    logic [8:0]  ones0;
    logic [15:0] sig0, golden0;

    int  mode;
    bit  tbl [256];
    bit  rdy_r = 1'b1;
    bit  rnd_rdy = 1'b0;
    bit  hold = 1'b0;

    logic [8:0]  q  [$];
    logic [8:0]  q0 [$];
    logic [8:0]  exp_words [32];
    int          exp_ones;
    logic [15:0] exp_sig;

    int pass_n = 0;
    int tot_n  = 0;

    function automatic bit fref(int m, logic [7:0] v);
        case (m)
            0:       return 1'b0;
            1:       return v[0];
            2:       return 1'b1;
            3:       return v[0] ^ (v == 8'h93);
            default: return tbl[v];
        endcase
    endfunction

    assign f_i       = fref(mode, vec_o);
    assign f0        = fref(mode, vec0);
    assign tt_ready  = rdy_r & ~hold;
    assign tt_ready0 = 1'b1;
    assign golden0   = 16'h0000;

    skolem_tt_sweeper #(
        .N_IN(8), .SETTLE(1), .WORD_W(8), .SIG_W(16), .POLY(16'h1021)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .vec_o(vec_o), .f_i(f_i), .tt_valid(tt_valid), .tt_ready(tt_ready),
        .tt_data(tt_data), .tt_last(tt_last), .ones_cnt(ones_cnt),
        .signature(signature), .golden_sig(golden_sig), .sig_match(sig_match)
    );

    skolem_tt_sweeper #(
        .N_IN(8), .SETTLE(0), .WORD_W(8), .SIG_W(16), .POLY(16'h1021)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .vec_o(vec0), .f_i(f0), .tt_valid(tt_valid0), .tt_ready(tt_ready0),
        .tt_data(tt_data0), .tt_last(tt_last0), .ones_cnt(ones0),
        .signature(sig0), .golden_sig(golden0), .sig_match(sig_match0)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic fail(string nm);
        tot_n++;
        $display("FAIL %s", nm);
    endtask

    // Reference: truth table packed LSB-first, CRC-16 over bits in vector order.
    task automatic compute(int m);
        bit b;
        exp_ones = 0;
        exp_sig  = 16'hFFFF;
        for (int w = 0; w < 32; w++) exp_words[w] = {(w == 31), 8'h00};
        for (int v = 0; v < 256; v++) begin
            b = fref(m, 8'(v));
            exp_ones += int'(b);
            exp_words[v / 8][v % 8] = b;
            exp_sig = (exp_sig << 1) ^ ((exp_sig[15] ^ b) ? 16'h1021 : 16'h0000);
        end
    endtask

    always @(posedge clk) begin
        #2;
        rdy_r = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        logic [8:0] e;
        #1;
        if (!rst && tt_valid && tt_ready) begin
            if (q.size() == 0) fail("unexpected word");
            else begin
                e = q.pop_front();
                chk("tt word", {23'b0, tt_last, tt_data}, {23'b0, e});
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        #1;
        if (!rst && tt_valid0 && tt_ready0) begin
            if (q0.size() == 0) fail("unexpected word s0");
            else begin
                e = q0.pop_front();
                chk("tt word s0", {23'b0, tt_last0, tt_data0}, {23'b0, e});
            end
        end
    end

    task automatic pulse_a();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_done_0(output int cyc);
        cyc = 0;
        while (!done0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic stall_word2();
        int n = 0;
        while (!(tt_valid && vec_o == 8'h17) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("word 2 never offered");
        hold = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("stall vec", {24'b0, vec_o}, 32'h17);
            chk("stall data", {24'b0, tt_data}, {24'b0, exp_words[2][7:0]});
            chk("stall valid", {31'b0, tt_valid}, 32'h1);
        end
        hold = 1'b0;
    endtask

    task automatic sweep_a(int m, bit rnd, bit bp, output int cyc);
        mode    = m;
        rnd_rdy = rnd;
        compute(m);
        for (int w = 0; w < 32; w++) q.push_back(exp_words[w]);
        pulse_a();
        fork
            wait_done_a(cyc);
            if (bp) stall_word2();
        join
        chk("done", {31'b0, done}, 32'h1);
        chk("ones_cnt", {23'b0, ones_cnt}, 32'(exp_ones));
        chk("signature", {16'b0, signature}, {16'b0, exp_sig});
        chk("words left", 32'(q.size()), 32'd0);
        rnd_rdy = 1'b0;
    endtask

    initial begin
        int          cyc, n;
        logic [15:0] sig1;
        rst = 1'b1;
        start = 1'b0;
        start0 = 1'b0;
        golden_sig = 16'h0000;
        mode = 0;
        for (int i = 0; i < 256; i++) tbl[i] = 1'($urandom_range(0, 1));
        repeat (3) @(posedge clk);
        #1;
        chk("rst vec", {24'b0, vec_o}, 32'h0);
        chk("rst busy/done/valid", {29'b0, busy, done, tt_valid}, 32'h0);
        chk("rst ones", {23'b0, ones_cnt}, 32'h0);
        chk("rst sig", {16'b0, signature}, 32'hFFFF);
        chk("rst sig0", {16'b0, sig0}, 32'hFFFF);
        rst = 1'b0;
        @(posedge clk); #1;

        sweep_a(0, 1'b0, 1'b0, cyc);
        chk("cycles f=0", 32'(cyc), 32'd544);

        sweep_a(1, 1'b0, 1'b0, cyc);
        chk("cycles f=v0", 32'(cyc), 32'd544);
        chk("ones f=v0", {23'b0, ones_cnt}, 32'd128);
        sig1 = signature;

        sweep_a(2, 1'b0, 1'b0, cyc);
        chk("ones f=1", {23'b0, ones_cnt}, 32'd256);

        sweep_a(1, 1'b0, 1'b1, cyc);
        chk("ones after stall", {23'b0, ones_cnt}, 32'd128);

        sweep_a(4, 1'b1, 1'b0, cyc);

        mode = 1;
        compute(1);
        for (int w = 0; w < 32; w++) q.push_back(exp_words[w]);
        pulse_a();
        n = 0;
        while (vec_o != 8'h40 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) fail("vec 0x40 not reached");
        #2;
        rst = 1'b1;
        #1;
        chk("midrst vec", {24'b0, vec_o}, 32'h0);
        chk("midrst flags", {27'b0, busy, done, tt_valid, tt_last, sig_match}, 32'h0);
        chk("midrst data/ones", {15'b0, tt_data, ones_cnt}, 32'h0);
        chk("midrst sig", {16'b0, signature}, 32'hFFFF);
        q.delete();
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        sweep_a(1, 1'b0, 1'b0, cyc);
        chk("sig after midrst", {16'b0, signature}, {16'b0, sig1});

        golden_sig = sig1;
        sweep_a(1, 1'b0, 1'b0, cyc);
        chk("sig_match golden", {31'b0, sig_match}, 32'h1);
        sweep_a(3, 1'b0, 1'b0, cyc);
        chk("sig_match flipped", {31'b0, sig_match}, 32'h0);
        chk("ones flipped", {23'b0, ones_cnt}, 32'd127);

        mode = 4;
        compute(4);
        for (int w = 0; w < 32; w++) q0.push_back(exp_words[w]);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        fork
            wait_done_0(cyc);
            begin
                repeat (5) begin
                    repeat ($urandom_range(5, 40)) @(posedge clk);
                    #1 start0 = 1'b1;
                    @(posedge clk);
                    #1 start0 = 1'b0;
                end
            end
        join
        chk("cycles s0", 32'(cyc), 32'd288);
        chk("ones s0", {23'b0, ones0}, 32'(exp_ones));
        chk("sig s0", {16'b0, sig0}, {16'b0, exp_sig});
        chk("words left s0", 32'(q0.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule

// File: doc/skolem_tt_sweeper.md
Name: skolem_tt_sweeper

Overview:
- Sequential harness stage downstream of the combinational Skolem-function netlists, e.g. the 8-input/1-output bvudiv Skolem function.
- Exhaustively drives all 2^N_IN input vectors into the attached function and samples its 1-bit output.
- Packs the resulting truth table into words and streams them out on a valid/ready interface.
- Accumulates a one-count and a CRC signature and compares the signature against a golden value, for regression of regenerated netlists.

Parameters:
N_IN, 8, number of function inputs; vec_o width.
SETTLE, 1, cycles vec_o is held before f_i is sampled (0 allowed).
WORD_W, 8, truth-table bits per output word; 2^N_IN must be a multiple of WORD_W.
SIG_W, 16, signature width.
POLY, 16'h1021, signature feedback polynomial (SIG_W bits).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; begins a sweep; honoured only in IDLE or DONE.
busy  out  1  high from the cycle after an accepted start until DONE is entered.
done  out  1  high while in DONE.
vec_o  out  N_IN  current input vector to the Skolem function.
f_i  in  1  Skolem function output for vec_o.
tt_valid  out  1  tt_data holds a full word.
tt_ready  in  1  consumer accepts the word when tt_valid && tt_ready.
tt_data  out  WORD_W  truth-table word; bit j = f(vec = word_index*WORD_W + j).
tt_last  out  1  qualifies the final word.
ones_cnt  out  N_IN+1  number of vectors with f_i = 1.
signature  out  SIG_W  CRC over the sampled bits in vector order.
golden_sig  in  SIG_W  expected signature.
sig_match  out  1  (signature == golden_sig) && done.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE.
  - All outputs 0.
  - signature = all-ones.
  - Internal counters cleared.
- FSM states: IDLE, DRIVE, SAMPLE, EMIT, DONE.
- IDLE/DONE, start = 1:
  - Clear vec_o, ones_cnt and the word shift register.
  - Set signature = all-ones and settle_cnt = SETTLE.
  - Go to DRIVE (or to SAMPLE if SETTLE = 0).
- DRIVE: decrement settle_cnt each cycle; at 0 go to SAMPLE. vec_o is stable throughout.
- SAMPLE (one cycle):
  - Shift f_i into bit position vec_o mod WORD_W.
  - ones_cnt += f_i.
  - Signature update: fb = sig[SIG_W-1] ^ f_i; sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : 0).
  - If vec_o mod WORD_W == WORD_W-1, go to EMIT.
  - Otherwise vec_o++, reload settle_cnt and go to DRIVE.
- EMIT:
  - tt_valid = 1; tt_data and tt_last are stable until the handshake.
  - vec_o is held during backpressure.
  - On handshake: if vec_o == 2^N_IN-1, go to DONE; else vec_o++, reload settle_cnt, go to DRIVE.
  - tt_valid drops in the cycle after the handshake.
- Latency:
  - Vector-to-sample is SETTLE+1 cycles.
  - With tt_ready tied high, a sweep takes 2^N_IN*(SETTLE+1) + 2^N_IN/WORD_W cycles from start to done.
- Wrap: vec_o never wraps inside a sweep. The last vector is 2^N_IN-1 and is held in DONE.
- start while busy is ignored. f_i changes outside SAMPLE are ignored.
- DONE:
  - done = 1 and busy = 0.
  - ones_cnt, signature and sig_match are held until the next start or rst.
- Reset mid-sweep: immediate return to IDLE, with no partial word emitted. A later start reproduces a full, uninterrupted sweep.
- Elaboration error if N_IN < log2(WORD_W), or if 2^N_IN mod WORD_W != 0.

Decomposition:
- Shared package skolem_harness_pkg holds:
  - the state enum;
  - the default POLY;
  - the signature-initial constant (all-ones).
- One sub-module, skolem_sig_crc: serial CRC register with clear/enable, reused by future multi-output harnesses.

Test Plan:
- N_IN=8, SETTLE=1, tt_ready=1, f_i=0 -> 32 words of 8'h00, the last with tt_last; ones_cnt=0; done asserted 544 cycles after start.
- f_i = vec_o[0] -> every word 8'hAA; ones_cnt=128. f_i=1 -> every word 8'hFF; ones_cnt=256.
- Backpressure: tt_ready low for 10 cycles while word 2 is offered -> vec_o holds 8'h17, tt_data holds its value, no vector is skipped or duplicated, and the final ones_cnt is unchanged versus the no-stall run.
- Reset mid-sweep: rst pulsed when vec_o=8'h40 -> all outputs 0 the same cycle; a new start gives a signature identical to the uninterrupted run.
- Golden check:
  - golden_sig set to the signature from the f_i=vec_o[0] run, then rerun -> sig_match=1.
  - Invert f_i for vector 8'h93 only -> sig_match=0 and ones_cnt differs by 1.
- SETTLE=0 and start pulses during busy -> one sample per cycle; 288 cycles to done; the extra starts have no effect.
